// File: rtl/systolic_feeder.sv
// Staging buffer for the 2x2 systolic array: one weight-load cycle, then lane-1-lagged activation stream.
// All outputs are registered; only wr_ready decodes state/count. `define FEEDER_REPLAY_EN retains the buffer for replay.
module systolic_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_a0,
  input  logic [DATA_W-1:0] wr_a1,
  input  logic              wr_last,
  input  logic [DATA_W-1:0] w_in1,
  input  logic [DATA_W-1:0] w_in2,
  input  logic [DATA_W-1:0] w_in3,
  input  logic [DATA_W-1:0] w_in4,
`ifdef FEEDER_REPLAY_EN
  input  logic              clear_buf,
`endif
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              load_weight,
  output logic              valid,
  output logic [DATA_W-1:0] a_in1,
  output logic [DATA_W-1:0] a_in2,
  output logic [DATA_W-1:0] weight1,
  output logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight3,
  output logic [DATA_W-1:0] weight4
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LOADW, S_STREAM, S_DONE} state_t;

  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] DEPTH_M1 = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);

  state_t state, state_nxt;
  logic [PTR_W:0] count, count_nxt, k, k_nxt;
  logic [2*DATA_W-1:0] vec_buf [DEPTH];
  logic accept, clr_req;
  logic busy_nxt, done_nxt, lw_nxt, valid_nxt;
  logic [DATA_W-1:0] a1_nxt, a2_nxt;
  logic [PTR_W-1:0] idx_cur, idx_prev;

`ifdef FEEDER_REPLAY_EN
  assign clr_req = clear_buf;
`else
  assign clr_req = 1'b0;
`endif

  assign wr_ready = (state == S_IDLE) && (count < DEPTH_C);
  assign accept   = wr_valid && wr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    k_nxt     = k;
    case (state)
      S_IDLE: begin
        // An accept in the same cycle as start takes priority; start is dropped.
        if (accept) begin
          count_nxt = count + ONE;
          if (wr_last || count == DEPTH_M1) state_nxt = S_ARMED;
        end else if (start && count != '0) begin
          state_nxt = S_LOADW;
        end
      end
      S_ARMED: begin
        if (clr_req) begin
          count_nxt = '0;
          state_nxt = S_IDLE;
        end else if (start) begin
          state_nxt = S_LOADW;
        end
      end
      S_LOADW: begin
        state_nxt = S_STREAM;
        k_nxt     = '0;
      end
      S_STREAM: begin
        if (k == count) state_nxt = S_DONE;
        else            k_nxt     = k + ONE;
      end
      S_DONE: begin
`ifdef FEEDER_REPLAY_EN
        state_nxt = S_ARMED;
`else
        state_nxt = S_IDLE;
        count_nxt = '0;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered values line up with the state they belong to.
  always_comb begin
    idx_cur   = k_nxt[PTR_W-1:0];
    idx_prev  = k_nxt[PTR_W-1:0] - 1'b1;
    busy_nxt  = (state_nxt == S_LOADW) || (state_nxt == S_STREAM);
    done_nxt  = (state_nxt == S_DONE);
    lw_nxt    = (state_nxt == S_LOADW);
    valid_nxt = (state_nxt == S_STREAM);
    a1_nxt    = '0;
    a2_nxt    = '0;
    if (state_nxt == S_STREAM) begin
      if (k_nxt < count) a1_nxt = vec_buf[idx_cur][DATA_W-1:0];
      if (k_nxt != '0)   a2_nxt = vec_buf[idx_prev][2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) vec_buf[count[PTR_W-1:0]] <= {wr_a1, wr_a0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      load_weight <= 1'b0;
      valid       <= 1'b0;
      a_in1       <= '0;
      a_in2       <= '0;
      weight1     <= '0;
      weight2     <= '0;
      weight3     <= '0;
      weight4     <= '0;
    end else begin
      busy        <= busy_nxt;
      done        <= done_nxt;
      load_weight <= lw_nxt;
      valid       <= valid_nxt;
      a_in1       <= a1_nxt;
      a_in2       <= a2_nxt;
      if (state_nxt == S_LOADW) begin
        weight1 <= w_in1;
        weight2 <= w_in2;
        weight3 <= w_in3;
        weight4 <= w_in4;
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed table-driven bench for systolic_feeder, plus mid-stream reset and replay sequences.
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic reset;
  logic wr_valid, wr_ready, wr_last, start;
  logic [15:0] wr_a0, wr_a1, w_in1, w_in2, w_in3, w_in4;
  logic busy, done, load_weight, valid;
  logic [15:0] a_in1, a_in2, weight1, weight2, weight3, weight4;
`ifdef FEEDER_REPLAY_EN
  logic clear_buf;
`endif

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_W(16), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_a0(wr_a0), .wr_a1(wr_a1), .wr_last(wr_last),
    .w_in1(w_in1), .w_in2(w_in2), .w_in3(w_in3), .w_in4(w_in4),
`ifdef FEEDER_REPLAY_EN
    .clear_buf(clear_buf),
`endif
    .start(start), .busy(busy), .done(done), .load_weight(load_weight), .valid(valid),
    .a_in1(a_in1), .a_in2(a_in2),
    .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4)
  );

  logic [100:0] outs;
  assign outs = {wr_ready, busy, done, load_weight, valid, a_in1, a_in2, weight1, weight2, weight3, weight4};

  localparam logic [63:0] W0    = 64'd0;
  localparam logic [63:0] W5678 = {16'd5, 16'd6, 16'd7, 16'd8};
  localparam logic [63:0] W1234 = {16'd1, 16'd2, 16'd3, 16'd4};
  localparam logic [63:0] W9999 = {16'd9, 16'd9, 16'd9, 16'd9};
  localparam logic [63:0] W7777 = {16'd7, 16'd7, 16'd7, 16'd7};

  typedef struct packed {
    logic         wv;
    logic [15:0]  a0;
    logic [15:0]  a1;
    logic         last;
    logic         st;
    logic [63:0]  wi;
    logic [100:0] exp;
  } vec_t;

  vec_t tbl[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic logic [100:0] ex(input logic rdy, bz, dn, lw, vl, input int x1, x2, input logic [63:0] ew);
    logic [15:0] p, q;
    p = x1[15:0];
    q = x2[15:0];
    return {rdy, bz, dn, lw, vl, p, q, ew};
  endfunction

  function automatic vec_t mk(input logic wv, input int a0, a1, input logic last, st,
                              input logic [63:0] wi, input logic [100:0] e);
    vec_t r;
    r.wv = wv; r.a0 = a0[15:0]; r.a1 = a1[15:0]; r.last = last; r.st = st; r.wi = wi; r.exp = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [100:0] act, input logic [100:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got {rdy,busy,done,lw,vld,a1,a2,w} %h, expected %h", nm, act, expv);
  endtask

  task automatic run(input vec_t r, input string nm);
    wr_valid = r.wv; wr_a0 = r.a0; wr_a1 = r.a1; wr_last = r.last; start = r.st;
    {w_in1, w_in2, w_in3, w_in4} = r.wi;
    @(posedge clk); #1;
    chk(nm, outs, r.exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr_valid = 0; wr_a0 = 0; wr_a1 = 0; wr_last = 0; start = 0;
    w_in1 = 0; w_in2 = 0; w_in3 = 0; w_in4 = 0;
`ifdef FEEDER_REPLAY_EN
    clear_buf = 0;
`endif
    #12;
    chk("reset_state", outs, ex(1,0,0,0,0,0,0,W0));
    @(posedge clk); #1;
    reset = 1'b0;

    // start with an empty buffer must never leave IDLE
    for (int i = 0; i < 10; i++) run(mk(0,0,0,0,1,W5678, ex(1,0,0,0,0,0,0,W0)), $sformatf("empty_start_%0d", i));

`ifndef FEEDER_REPLAY_EN
    // two vectors, wr_last on the second
    tbl.push_back(mk(1,1,2,0,0,W0,    ex(1,0,0,0,0,0,0,W0)));
    tbl.push_back(mk(1,3,4,1,0,W0,    ex(0,0,0,0,0,0,0,W0)));
    tbl.push_back(mk(0,0,0,0,1,W5678, ex(0,1,0,1,0,0,0,W5678)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,1,0,W5678)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,3,2,W5678)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,0,4,W5678)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(0,0,1,0,0,0,0,W5678)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(1,0,0,0,0,0,0,W5678)));
    // full buffer without wr_last; fifth offer dropped in ARMED
    tbl.push_back(mk(1,10,11,0,0,W0,  ex(1,0,0,0,0,0,0,W5678)));
    tbl.push_back(mk(1,12,13,0,0,W0,  ex(1,0,0,0,0,0,0,W5678)));
    tbl.push_back(mk(1,14,15,0,0,W0,  ex(1,0,0,0,0,0,0,W5678)));
    tbl.push_back(mk(1,16,17,0,0,W0,  ex(0,0,0,0,0,0,0,W5678)));
    tbl.push_back(mk(1,99,99,0,0,W0,  ex(0,0,0,0,0,0,0,W5678)));
    tbl.push_back(mk(0,0,0,0,1,W1234, ex(0,1,0,1,0,0,0,W1234)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,10,0,W1234)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,12,11,W1234)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,14,13,W1234)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,16,15,W1234)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,0,17,W1234)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(0,0,1,0,0,0,0,W1234)));
    tbl.push_back(mk(0,0,0,0,0,W0,    ex(1,0,0,0,0,0,0,W1234)));
    // accept and start together: vector kept, start dropped; start/wr_valid ignored while busy
    tbl.push_back(mk(1,20,21,0,1,W9999, ex(1,0,0,0,0,0,0,W1234)));
    tbl.push_back(mk(0,0,0,0,0,W0,      ex(1,0,0,0,0,0,0,W1234)));
    tbl.push_back(mk(0,0,0,0,1,W9999,   ex(0,1,0,1,0,0,0,W9999)));
    tbl.push_back(mk(0,0,0,0,1,W7777,   ex(0,1,0,0,1,20,0,W9999)));
    tbl.push_back(mk(1,50,51,0,0,W0,    ex(0,1,0,0,1,0,21,W9999)));
    tbl.push_back(mk(0,0,0,0,1,W7777,   ex(0,0,1,0,0,0,0,W9999)));
    tbl.push_back(mk(0,0,0,0,0,W0,      ex(1,0,0,0,0,0,0,W9999)));
    tbl.push_back(mk(0,0,0,0,1,W7777,   ex(1,0,0,0,0,0,0,W9999)));
    foreach (tbl[i]) run(tbl[i], $sformatf("row_%0d", i));
`endif

    // reset during the second stream cycle
    pulse_reset();
    run(mk(1,1,2,1,0,W0,    ex(0,0,0,0,0,0,0,W0)), "mid_fill");
    run(mk(0,0,0,0,1,W5678, ex(0,1,0,1,0,0,0,W5678)), "mid_loadw");
    run(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,1,0,W5678)), "mid_s0");
    wr_valid = 0; start = 0;
    @(posedge clk); #1;
    chk("mid_s1", outs, ex(0,1,0,0,1,0,2,W5678));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset", outs, ex(1,0,0,0,0,0,0,W0));
    reset = 1'b0;
    run(mk(0,0,0,0,0,W0, ex(1,0,0,0,0,0,0,W0)), "mid_no_done");
    run(mk(0,0,0,0,0,W0, ex(1,0,0,0,0,0,0,W0)), "mid_no_done2");
    run(mk(1,5,6,0,0,W0,    ex(1,0,0,0,0,0,0,W0)), "fresh_w0");
    run(mk(1,7,8,1,0,W0,    ex(0,0,0,0,0,0,0,W0)), "fresh_w1");
    run(mk(0,0,0,0,1,W1234, ex(0,1,0,1,0,0,0,W1234)), "fresh_loadw");
    run(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,5,0,W1234)), "fresh_s0");
    run(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,7,6,W1234)), "fresh_s1");
    run(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,0,8,W1234)), "fresh_s2");
    run(mk(0,0,0,0,0,W0,    ex(0,0,1,0,0,0,0,W1234)), "fresh_done");
`ifdef FEEDER_REPLAY_EN
    run(mk(1,9,9,0,0,W0,    ex(0,0,0,0,0,0,0,W1234)), "rep_armed");
    run(mk(0,0,0,0,1,W5678, ex(0,1,0,1,0,0,0,W5678)), "rep_loadw");
    run(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,5,0,W5678)), "rep_s0");
    run(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,7,6,W5678)), "rep_s1");
    run(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,0,8,W5678)), "rep_s2");
    run(mk(0,0,0,0,0,W0,    ex(0,0,1,0,0,0,0,W5678)), "rep_done");
    run(mk(0,0,0,0,0,W0,    ex(0,0,0,0,0,0,0,W5678)), "rep_armed2");
    clear_buf = 1'b1;
    run(mk(0,0,0,0,0,W0,    ex(1,0,0,0,0,0,0,W5678)), "rep_clear");
    clear_buf = 1'b0;
    run(mk(1,1,2,0,0,W0,    ex(1,0,0,0,0,0,0,W5678)), "rep_new_wr");
    run(mk(0,0,0,0,1,W9999, ex(0,1,0,1,0,0,0,W9999)), "rep_new_loadw");
    run(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,1,0,W9999)), "rep_new_s0");
    run(mk(0,0,0,0,0,W0,    ex(0,1,0,0,1,0,2,W9999)), "rep_new_s1");
`else
    run(mk(0,0,0,0,0,W0,    ex(1,0,0,0,0,0,0,W1234)), "fresh_idle");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
